fetch_pc_gen: RTL
=================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_2000, is the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), is the bubble instruction.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pc_sel  input  2  next-PC select: 00 replay, 01 target, 10 sequential, 11 reserved.
REQ-006 alu_target  input  32  redirect address, used when pc_sel=01.
REQ-007 stall  input  1  freezes the fetch stage.
REQ-008 icache_dout  input  32  synchronous-read instruction; valid the cycle after its address is presented.
REQ-009 icache_addr  output  32  combinational fetch address for the next cycle.
REQ-010 icache_re  output  1  read enable.
REQ-011 fetch_pc  output  32  PC of the instruction currently on icache_dout.
REQ-012 prev_inst  output  32  registered instruction handed to decode and next-PC select logic.
REQ-013 prev_pc  output  32  PC paired with prev_inst.
REQ-014 redirect_cnt  output  16  count of accepted pc_sel=01 redirects.
REQ-015 bubble_cnt  output  16  count of NOP_INST insertions into prev_inst.

Function
REQ-016 The FSM SHALL have two states: BOOT (entered on reset) and RUN.
REQ-017 In BOOT: icache_addr=RESET_PC, icache_re=1, pc_sel and stall ignored; next edge loads fetch_pc<=RESET_PC, prev_inst<=NOP_INST, prev_pc<=RESET_PC, bubble_cnt+1, state<=RUN.
REQ-018 In RUN with stall=1: icache_addr=fetch_pc, icache_re=1, and fetch_pc, prev_inst, prev_pc, counters and state hold.
REQ-019 In RUN with stall=0 and pc_sel=10 or 11: icache_addr=fetch_pc+4 (modulo 2^32); next edge loads fetch_pc<=icache_addr, prev_inst<=icache_dout, prev_pc<=fetch_pc.
REQ-020 In RUN with stall=0 and pc_sel=01: icache_addr=alu_target; next edge loads fetch_pc<=alu_target, prev_inst<=NOP_INST, prev_pc<=fetch_pc, redirect_cnt+1, bubble_cnt+1.
REQ-021 In RUN with stall=0 and pc_sel=00: icache_addr=fetch_pc; next edge keeps fetch_pc, loads prev_inst<=NOP_INST, prev_pc<=fetch_pc, bubble_cnt+1.
REQ-022 Stall SHALL take priority over pc_sel in the same cycle; the upstream logic holds pc_sel until stall deasserts.
REQ-023 Redirect penalty SHALL be exactly one bubble: the target instruction is on icache_dout the cycle after pc_sel=01 is accepted.
REQ-024 alu_target bits [1:0] SHALL be forced to 00.
REQ-025 Counters SHALL saturate at 16'hFFFF.
REQ-026 icache_re SHALL be 0 only while rst_n is low.

Reset
REQ-027 While rst_n=0: state=BOOT, fetch_pc=RESET_PC, prev_inst=NOP_INST, prev_pc=RESET_PC, counters=0, icache_re=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight fetches; after release, the first fetch is RESET_PC.

Structure
REQ-029 pc_sel encodings (PC_REPLAY, PC_TARGET, PC_SEQ), NOP_INST and the FSM state encoding belong in the shared fetch package, also used by the next-PC select logic.
REQ-030 One sub-module, sat_counter16 (increment enable, saturate), instantiated twice for the counters.

Verification
REQ-031 Reset release, pc_sel=10 for 3 cycles, memory word at 0x2000=0x00500093 -> icache_addr sequence 0x2000, 0x2004, 0x2008, 0x200C; prev_inst=0x00500093 in cycle 2; bubble_cnt=1.
REQ-032 At fetch_pc=0x2008, pc_sel=01, alu_target=0x2100 -> icache_addr=0x2100 that cycle, prev_inst=0x00000013 next cycle, fetch_pc=0x2100, redirect_cnt=1.
REQ-033 stall=1 for 2 cycles at fetch_pc=0x2004 with pc_sel=01 -> icache_addr=0x2004 both cycles, no counter change; redirect taken on the first cycle with stall=0.
REQ-034 pc_sel=00 at fetch_pc=0x2010 -> icache_addr=0x2010, prev_inst=NOP_INST, fetch_pc unchanged, bubble_cnt+1.
REQ-035 rst_n pulsed low during a redirect to 0x3000 -> outputs at reset values immediately; after release, first icache_addr=0x2000 and no fetch from 0x3000.
REQ-036 fetch_pc=0xFFFF_FFFC with pc_sel=10 -> icache_addr=0x0000_0000; 70000 redirects -> redirect_cnt=0xFFFF.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch definitions: next-PC select encodings, bubble word, FSM states.
package fetch_pc_gen_pkg;

    typedef enum logic [1:0] {
        PC_REPLAY = 2'b00,
        PC_TARGET = 2'b01,
        PC_SEQ    = 2'b10
    } pc_sel_e;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

endpackage

// File: rtl/fetch_pc_gen_sat_counter16.sv
// 16-bit event counter that sticks at its maximum instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);
    import fetch_pc_gen_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && count != CNT_MAX) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: picks the next fetch address and registers the
// instruction/PC pair handed to decode.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = fetch_pc_gen_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] alu_target,
    input  logic        stall,
    input  logic [31:0] icache_dout,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    output logic [31:0] fetch_pc,
    output logic [31:0] prev_inst,
    output logic [31:0] prev_pc,
    output logic [15:0] redirect_cnt,
    output logic [15:0] bubble_cnt
);
    import fetch_pc_gen_pkg::*;

    fetch_state_e state;

    logic        is_boot;
    logic        hold;
    logic        go_tgt;
    logic        go_rep;
    logic        go_seq;
    logic        redirect;
    logic        bubble;
    logic [31:0] tgt_al;

    assign tgt_al  = {alu_target[31:2], 2'b00};
    assign is_boot = (state == BOOT);
    assign hold    = !is_boot && stall;
    assign go_tgt  = !is_boot && !stall && (pc_sel == PC_TARGET);
    assign go_rep  = !is_boot && !stall && (pc_sel == PC_REPLAY);
    assign go_seq  = !is_boot && !stall && pc_sel[1];

    // The cache is only idle while reset is held.
    assign icache_re = rst_n;

    always_comb begin
        icache_addr = fetch_pc;
        redirect    = 1'b0;
        bubble      = 1'b0;
        unique case (1'b1)
            is_boot: begin
                icache_addr = RESET_PC;
                bubble      = 1'b1;
            end
            hold: begin
                icache_addr = fetch_pc;
            end
            go_tgt: begin
                icache_addr = tgt_al;
                redirect    = 1'b1;
                bubble      = 1'b1;
            end
            go_rep: begin
                icache_addr = fetch_pc;
                bubble      = 1'b1;
            end
            go_seq: begin
                icache_addr = fetch_pc + 32'd4;
            end
            default: begin
                icache_addr = fetch_pc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            fetch_pc  <= RESET_PC;
            prev_inst <= NOP_INST;
            prev_pc   <= RESET_PC;
        end else begin
            unique case (state)
                BOOT: begin
                    state     <= RUN;
                    fetch_pc  <= RESET_PC;
                    prev_inst <= NOP_INST;
                    prev_pc   <= RESET_PC;
                end
                RUN: begin
                    if (!stall) begin
                        fetch_pc  <= icache_addr;
                        prev_pc   <= fetch_pc;
                        prev_inst <= go_seq ? icache_dout : NOP_INST;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    sat_counter16 u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect),
        .count (redirect_cnt)
    );

    sat_counter16 u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble),
        .count (bubble_cnt)
    );

endmodule
